// File: rtl/dmem_arb_if.sv
// Data-memory arbiter bus bundle.
//
// Groups both requester ports (m0 = core, m1 = debug/DMA), the single-port
// memory command/response signals and the core stall output.
//   modport slave  : used by the arbiter (dmem_arb)
//   modport master : used by the environment that drives the requests and
//                    the memory read data
interface dmem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_W-1:0]     m0_addr;
   logic [DATA_W-1:0]     m0_wdata;
   logic [DATA_W/8-1:0]   m0_be;
   logic                  m0_gnt;
   logic                  m0_rvalid;
   logic [DATA_W-1:0]     m0_rdata;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_W-1:0]     m1_addr;
   logic [DATA_W-1:0]     m1_wdata;
   logic [DATA_W/8-1:0]   m1_be;
   logic                  m1_gnt;
   logic                  m1_rvalid;
   logic [DATA_W-1:0]     m1_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;

   logic                  stall;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
      input  mem_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      output stall
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
      output mem_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      input  stall
   );
endinterface

// File: rtl/dmem_arb.sv
// Two-master arbiter for a single-port data memory.
//
// m0 (core) and m1 (debug/DMA) share one memory port. A grant is combinational
// from the requests and registered arbitration state, so a lone requester is
// served in the same cycle and one access can be issued every cycle. Read data
// returns one cycle after the command and is steered back to the issuing
// master by a 1-bit tag plus a read-pending flag.
//
// Default build: fixed priority, m0 wins ties, but m1 is forced through after
// STARVE_MAX consecutive m0 grants while m1 is waiting.
// With DMEM_ARB_RR_EN defined: round-robin on ties, no starvation counter.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_arb_if.slave (m0_*, m1_*, mem_*, stall)
module dmem_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         reset,
   dmem_arb_if.slave    bus
);

   logic gnt0;
   logic gnt1;
   logic rd_issue;

   // Response routing: tag 0 -> m0, 1 -> m1.
   logic pend_q, pend_d;
   logic tag_q,  tag_d;

`ifdef DMEM_ARB_RR_EN
   // last_q = 1: m0 was granted most recently, so m1 wins the next tie.
   // last_q = 0: m1 was granted most recently (or reset), so m0 wins.
   logic last_q, last_d;
`else
   localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             starve;

   assign starve = (cnt_q == STARVE_LIM);
`endif

   // Grant decision; forced low while reset is asserted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = ~last_q;
            gnt1 =  last_q;
`else
            gnt0 = ~starve;
            gnt1 =  starve;
`endif
         end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
         end
      end
   end

   assign bus.m0_gnt = gnt0;
   assign bus.m1_gnt = gnt1;
   assign bus.stall  = bus.m0_req & ~gnt0 & ~reset;

   // Memory command mux; all-zero when idle.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      if (gnt0) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.m0_we;
         bus.mem_addr  = bus.m0_addr;
         bus.mem_wdata = bus.m0_wdata;
         bus.mem_be    = bus.m0_be;
      end else if (gnt1) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.m1_we;
         bus.mem_addr  = bus.m1_addr;
         bus.mem_wdata = bus.m1_wdata;
         bus.mem_be    = bus.m1_be;
      end
   end

   assign rd_issue = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);

   // Pending is rewritten every cycle, so back-to-back reads from either
   // master each get exactly one rvalid the following cycle.
   always_comb begin
      pend_d = rd_issue;
      tag_d  = rd_issue ? gnt1 : tag_q;
   end

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      last_d = last_q;
      if (gnt0)
         last_d = 1'b1;
      else if (gnt1)
         last_d = 1'b0;
   end
`else
   // Counts consecutive m0 grants while m1 waits; saturates at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (gnt1 || !bus.m1_req)
         cnt_d = '0;
      else if (gnt0 && !starve)
         cnt_d = cnt_q + CNT_W'(1);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
         tag_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_q <= 1'b0;
`else
         cnt_q  <= '0;
`endif
      end else begin
         pend_q <= pend_d;
         tag_q  <= tag_d;
`ifdef DMEM_ARB_RR_EN
         last_q <= last_d;
`else
         cnt_q  <= cnt_d;
`endif
      end
   end

   assign bus.m0_rvalid = pend_q & ~tag_q;
   assign bus.m1_rvalid = pend_q &  tag_q;
   assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
   assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arb.sv
module tb_dmem_arb;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   dmem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory model: word-addressed, read data one cycle after a read command.
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (reset) begin
         mem[24]       <= 32'h19;
         bus.mem_rdata <= 32'h0;
      end else if (bus.mem_en) begin
         if (bus.mem_we)
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
         else
            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic m0_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      bus.m0_req   = req;
      bus.m0_we    = we;
      bus.m0_addr  = addr;
      bus.m0_wdata = wdata;
      bus.m0_be    = 4'hF;
   endtask

   task automatic m1_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      bus.m1_req   = req;
      bus.m1_we    = we;
      bus.m1_addr  = addr;
      bus.m1_wdata = wdata;
      bus.m1_be    = 4'hF;
   endtask

   initial begin
      logic exp_g1;
      logic prev_g1;
      reset = 1'b1;
      m0_drive(1'b1, 1'b0, 32'd8, 32'd0);
      m1_drive(1'b1, 1'b1, 32'd12, 32'd7);

      // Outputs held at zero during reset even with requests pending.
      repeat (3) @(posedge clk);
      #2;
      chk("rst_m0_gnt", bus.m0_gnt, 0);
      chk("rst_m1_gnt", bus.m1_gnt, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_m0_rvalid", bus.m0_rvalid, 0);
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;

      // m0 write, m1 idle.
      cyc();
      m0_drive(1'b1, 1'b1, 32'd100, 32'd25);
      #1;
      chk("wr_m0_gnt", bus.m0_gnt, 1);
      chk("wr_m1_gnt", bus.m1_gnt, 0);
      chk("wr_mem_en", bus.mem_en, 1);
      chk("wr_mem_we", bus.mem_we, 1);
      chk("wr_mem_addr", bus.mem_addr, 100);
      chk("wr_mem_wdata", bus.mem_wdata, 25);
      chk("wr_mem_be", bus.mem_be, 4'hF);
      chk("wr_stall", bus.stall, 0);
      cyc();
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("wr_no_rvalid0", bus.m0_rvalid, 0);
      chk("wr_no_rvalid1", bus.m1_rvalid, 0);
      chk("idle_mem_en", bus.mem_en, 0);

      // m1 read of 96 returns 0x19.
      cyc();
      m1_drive(1'b1, 1'b0, 32'd96, 32'd0);
      #1;
      chk("rd1_m1_gnt", bus.m1_gnt, 1);
      chk("rd1_m0_gnt", bus.m0_gnt, 0);
      chk("rd1_mem_we", bus.mem_we, 0);
      chk("rd1_mem_addr", bus.mem_addr, 96);
      chk("rd1_stall", bus.stall, 0);
      cyc();
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("rd1_m1_rvalid", bus.m1_rvalid, 1);
      chk("rd1_m1_rdata", bus.m1_rdata, 32'h19);
      chk("rd1_m0_rvalid", bus.m0_rvalid, 0);
      chk("rd1_m0_rdata", bus.m0_rdata, 0);
      cyc();
      chk("rd1_rvalid_once", bus.m1_rvalid, 0);

      // Back-to-back reads from alternating masters.
      m0_drive(1'b1, 1'b0, 32'd100, 32'd0);
      #1;
      chk("alt_m0_gnt", bus.m0_gnt, 1);
      cyc();
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      m1_drive(1'b1, 1'b0, 32'd96, 32'd0);
      #1;
      chk("alt_m1_gnt", bus.m1_gnt, 1);
      chk("alt_m0_rvalid", bus.m0_rvalid, 1);
      chk("alt_m0_rdata", bus.m0_rdata, 25);
      chk("alt_m1_rvalid_a", bus.m1_rvalid, 0);
      cyc();
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("alt_m1_rvalid", bus.m1_rvalid, 1);
      chk("alt_m1_rdata", bus.m1_rdata, 32'h19);
      chk("alt_m0_rvalid_b", bus.m0_rvalid, 0);

      // Continuous contention: m0 reads 96 (0x19), m1 reads 100 (25).
      prev_g1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         m0_drive(1'b1, 1'b0, 32'd96, 32'd0);
         m1_drive(1'b1, 1'b0, 32'd100, 32'd0);
         #1;
`ifdef DMEM_ARB_RR_EN
         exp_g1 = (i % 2) == 1;
`else
         exp_g1 = (i % 5) == 4;
`endif
         chk($sformatf("arb_m1_gnt_%0d", i), bus.m1_gnt, exp_g1);
         chk($sformatf("arb_m0_gnt_%0d", i), bus.m0_gnt, !exp_g1);
         chk($sformatf("arb_stall_%0d", i), bus.stall, exp_g1);
         if (i > 0) begin
            chk($sformatf("arb_m1_rv_%0d", i), bus.m1_rvalid, prev_g1);
            chk($sformatf("arb_m0_rv_%0d", i), bus.m0_rvalid, !prev_g1);
            chk($sformatf("arb_m1_rd_%0d", i), bus.m1_rdata, prev_g1 ? 32'd25 : 32'd0);
            chk($sformatf("arb_m0_rd_%0d", i), bus.m0_rdata, prev_g1 ? 32'd0 : 32'h19);
         end
         prev_g1 = exp_g1;
      end
      cyc();
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("arb_last_m1_rv", bus.m1_rvalid, prev_g1);
      chk("arb_last_m0_rv", bus.m0_rvalid, !prev_g1);

`ifndef DMEM_ARB_RR_EN
      // m1 withdraws for one cycle mid-count: counter restarts from zero.
      for (int i = 0; i < 8; i++) begin
         cyc();
         m0_drive(1'b1, 1'b0, 32'd96, 32'd0);
         m1_drive(i != 2, 1'b0, 32'd100, 32'd0);
         #1;
         exp_g1 = (i == 7);
         chk($sformatf("wd_m1_gnt_%0d", i), bus.m1_gnt, exp_g1);
         chk($sformatf("wd_m0_gnt_%0d", i), bus.m0_gnt, !exp_g1);
      end
      cyc();
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
`endif

      // Reset asserted the cycle after an m0 read grant.
      cyc();
      m0_drive(1'b1, 1'b0, 32'd96, 32'd0);
      #1;
      chk("rr_m0_gnt", bus.m0_gnt, 1);
      cyc();
      reset = 1'b1;
      m1_drive(1'b1, 1'b1, 32'd100, 32'd5);
      #1;
      chk("rr_m0_rvalid", bus.m0_rvalid, 0);
      chk("rr_m0_rdata", bus.m0_rdata, 0);
      chk("rr_m0_gnt_rst", bus.m0_gnt, 0);
      chk("rr_m1_gnt_rst", bus.m1_gnt, 0);
      chk("rr_mem_en", bus.mem_en, 0);
      chk("rr_mem_addr", bus.mem_addr, 0);
      chk("rr_mem_wdata", bus.mem_wdata, 0);
      chk("rr_stall", bus.stall, 0);
      cyc();
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      #1;
      chk("rr_post_rv0", bus.m0_rvalid, 0);
      cyc();
      chk("rr_post_rv1", bus.m0_rvalid, 0);

      // First access after reset: tie goes to m0.
      m0_drive(1'b1, 1'b0, 32'd96, 32'd0);
      m1_drive(1'b1, 1'b0, 32'd100, 32'd0);
      #1;
      chk("first_m0_gnt", bus.m0_gnt, 1);
      chk("first_m1_gnt", bus.m1_gnt, 0);
      cyc();
      m0_drive(1'b0, 1'b0, 32'd0, 32'd0);
      m1_drive(1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("first_m0_rvalid", bus.m0_rvalid, 1);
      chk("first_m0_rdata", bus.m0_rdata, 32'h19);
      chk("first_m1_rvalid", bus.m1_rvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_MAX, 4, maximum consecutive m0 grants while m1 waits (fixed-priority mode only).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 m0_req, m0_we  in  1  core request and write enable; held until granted.
REQ-005 m0_addr  in  ADDR_W; m0_wdata  in  DATA_W; m0_be  in  DATA_W/8  core address, write data, byte enables.
REQ-006 m0_gnt  out  1; m0_rvalid  out  1; m0_rdata  out  DATA_W  core grant, read-response valid, read data.
REQ-007 m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata SHALL mirror the m0 ports for the debug/DMA requester.
REQ-008 mem_en, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8  single-port data memory command.
REQ-009 mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after a read command.
REQ-010 stall  out  1  high when m0_req is high and m0_gnt is low (freezes the core PC).

Function
REQ-011 At most one of m0_gnt, m1_gnt SHALL be high in any cycle; gnt is combinational from the req inputs and registered arbitration state.
REQ-012 A granted request SHALL drive mem_en=1 and the winner's we/addr/wdata/be onto mem_* in the same cycle; with no grant, mem_en=0, mem_we=0, and the other mem_* outputs hold 0.
REQ-013 Writes SHALL complete in the grant cycle and produce no rvalid.
REQ-014 A granted read SHALL assert the winner's rvalid for exactly one cycle, one cycle after grant, with rdata=mem_rdata; the non-winner's rdata SHALL be 0.
REQ-015 A 1-bit response-tag register plus a read-pending flag SHALL route responses, so back-to-back reads from alternating masters return to the correct master every cycle.
REQ-016 Grants SHALL be issuable every cycle, giving a throughput of one access per cycle.
REQ-017 With a single requester active, that requester SHALL be granted in the same cycle with zero added latency.
REQ-018 Fixed-priority mode: m0 SHALL win ties; a saturating counter SHALL count consecutive m0 grants while m1_req=1.
REQ-019 When the counter equals STARVE_MAX and m1_req=1, m1 SHALL be granted, and the counter SHALL clear on any m1 grant or any cycle with m1_req=0.
REQ-020 A deasserted req without grant SHALL be treated as withdrawn, with no state change beyond the counter clear rule.
REQ-021 A read issued in the cycle before reset asserts SHALL NOT produce an rvalid after reset releases.

Reset
REQ-022 While reset=1, all gnt, rvalid, mem_en, mem_we and stall SHALL be 0, and all rdata and mem_* buses SHALL be 0.
REQ-023 While reset=1, the response tag, read-pending flag, starvation counter and last-grant pointer SHALL be 0.
REQ-024 The first access after reset release SHALL follow normal arbitration, with m0 preferred.

Configuration
REQ-025 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the master not granted most recently wins, and the last-grant pointer updates on every grant.
REQ-026 With DMEM_ARB_RR_EN defined, the starvation counter and STARVE_MAX SHALL be absent.
REQ-027 Without DMEM_ARB_RR_EN, REQ-018 and REQ-019 fixed priority with starvation limit SHALL apply.

Verification
REQ-028 m0 write, addr=100, wdata=25, be=4'hF, m1 idle -> same-cycle m0_gnt=1, mem_we=1, mem_addr=100, mem_wdata=25, stall=0.
REQ-029 m1 read, addr=96, memory returns 0x19 -> m1_gnt in cycle N, m1_rvalid=1 with m1_rdata=0x19 in cycle N+1, m0_rvalid=0.
REQ-030 Fixed priority, m0 and m1 both requesting reads continuously -> 4 consecutive m0 grants, then 1 m1 grant, repeating; stall=1 only in the m1 grant cycles.
REQ-031 DMEM_ARB_RR_EN defined, both masters requesting continuously -> grants alternate m0, m1, m0, m1 starting with m0 after reset; each rvalid lands on the correct master.
REQ-032 Reset asserted one cycle after an m0 read grant -> no m0_rvalid during or after reset, and all outputs are 0 while reset=1.
